sv_mul: RTL and testbench

Attention-value multiplier, stage after score normalisation in the self-attention datapath. Reads the SEQ_LEN×SEQ_LEN fixed-point score matrix in the same flat layout the QK^T stage writes. Fetches V one row at a time over a request/valid handshake and accumulates `out[i][d] = Σ_j score[i][j]·V[j][d]`. Saturates the sums to DATA_WIDTH and presents the SEQ_LEN×EMBED_DIM result on a flat bus with a one-cycle done pulse.

---
 rtl/attn_pkg.sv | 29 ++
 rtl/sv_mul_if.sv | 16 +
 rtl/sv_mul_fx_mac.sv | 46 ++++
 rtl/sv_mul.sv | 159 +++++++++++++++
 tb/tb_sv_mul.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/attn_pkg.sv
// Shared types and helpers for the self-attention datapath stages.
package attn_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_MAC, S_DRAIN, S_SAT, S_DONE
  } sv_state_t;

  localparam int SAT_MAX_W = 64;

  // Accumulator width that absorbs SEQ_LEN full-scale products without overflow.
  function automatic int acc_w(input int data_width, input int seq_len);
    return 2 * data_width + $clog2(seq_len);
  endfunction

  // Clamp a signed value to the signed range of a w-bit word; caller truncates.
  function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
    lo = -hi - SAT_MAX_W'(1);
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/sv_mul_if.sv
// V-row fetch channel: master requests row v_addr, slave returns it with v_valid.
interface sv_mul_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int EMBED_DIM  = 64
);
  localparam int AW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic                            v_req;
  logic [AW-1:0]                   v_addr;
  logic                            v_valid;
  logic [DATA_WIDTH*EMBED_DIM-1:0] v_row;

  modport master (output v_req, v_addr, input  v_valid, v_row);
  modport slave  (input  v_req, v_addr, output v_valid, v_row);
endinterface

// File: rtl/sv_mul_fx_mac.sv
// Two-stage signed fixed-point multiply/shift pipeline; tag rides along with valid.
module fx_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int TAG_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_vld,
  input  logic [TAG_W-1:0]               in_tag,
  input  logic signed [DATA_WIDTH-1:0]   a,
  input  logic signed [DATA_WIDTH-1:0]   b,
  output logic                           out_vld,
  output logic [TAG_W-1:0]               out_tag,
  output logic signed [2*DATA_WIDTH-1:0] out_val
);
  localparam int STAGES = 2;
  localparam int PW     = 2 * DATA_WIDTH;

  logic [STAGES-1:0]            vld_pipe_d, vld_pipe_q;
  logic [STAGES-1:0][TAG_W-1:0] tag_pipe_d, tag_pipe_q;
  logic signed [PW-1:0]         prod_d, prod_q, sh_d, sh_q;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], in_vld};
    tag_pipe_d = {tag_pipe_q[STAGES-2:0], in_tag};
    prod_d     = PW'(a) * PW'(b);
    // Arithmetic shift floors toward -inf, matching the accumulate rule.
    sh_d       = prod_q >>> FRAC_BITS;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  always_ff @(posedge clk) begin
    tag_pipe_q <= tag_pipe_d;
    prod_q     <= prod_d;
    sh_q       <= sh_d;
  end

  assign out_vld = vld_pipe_q[STAGES-1];
  assign out_tag = tag_pipe_q[STAGES-1];
  assign out_val = sh_q;
endmodule

// File: rtl/sv_mul.sv
// Attention-value multiply: out = sat(score * V), V streamed one row per pass.
module sv_mul
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 64,
  parameter int EMBED_DIM  = 64,
  parameter int FRAC_BITS  = 14
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [SEQ_LEN*SEQ_LEN*DATA_WIDTH-1:0]     scores_flat,
  sv_mul_if.master                                  vif,
  output logic                                      busy,
  output logic                                      done,
  output logic [SEQ_LEN*EMBED_DIM*DATA_WIDTH-1:0]   out_flat
);
  localparam int NOUT  = SEQ_LEN * EMBED_DIM;
  localparam int AW    = (SEQ_LEN   > 1) ? $clog2(SEQ_LEN)   : 1;
  localparam int EW    = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam int KW    = (NOUT      > 1) ? $clog2(NOUT)      : 1;
  localparam int ACC_W = acc_w(DATA_WIDTH, SEQ_LEN);
  localparam int PW    = 2 * DATA_WIDTH;

  sv_state_t                       state_d, state_q;
  logic [AW-1:0]                   j_d, j_q, i_d, i_q;
  logic [EW-1:0]                   d_d, d_q;
  logic [KW-1:0]                   k_d, k_q;
  logic                            drain_d, drain_q;
  logic [DATA_WIDTH*EMBED_DIM-1:0] vrow_d, vrow_q;
  logic [NOUT*DATA_WIDTH-1:0]      out_flat_d, out_flat_q;
  logic signed [ACC_W-1:0]         acc_d [NOUT];
  logic signed [ACC_W-1:0]         acc_q [NOUT];

  logic                            acc_clr, mac_issue, mac_vld;
  logic [KW-1:0]                   mac_tag;
  logic signed [PW-1:0]            mac_val;
  logic signed [DATA_WIDTH-1:0]    score_sel, v_sel;

  assign score_sel = scores_flat[(int'(i_q) * SEQ_LEN + int'(j_q)) * DATA_WIDTH +: DATA_WIDTH];
  assign v_sel     = vrow_q[int'(d_q) * DATA_WIDTH +: DATA_WIDTH];

  fx_mac #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS), .TAG_W(KW)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (mac_issue),
    .in_tag  (k_q),
    .a       (score_sel),
    .b       (v_sel),
    .out_vld (mac_vld),
    .out_tag (mac_tag),
    .out_val (mac_val)
  );

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    i_d       = i_q;
    d_d       = d_q;
    k_d       = k_q;
    drain_d   = drain_q;
    vrow_d    = vrow_q;
    acc_clr   = 1'b0;
    mac_issue = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        acc_clr = 1'b1;
        j_d     = '0;
        state_d = S_REQ;
      end
      S_REQ: if (vif.v_valid) begin
        vrow_d  = vif.v_row;
        i_d     = '0;
        d_d     = '0;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        mac_issue = 1'b1;
        k_d       = k_q + KW'(1);
        if (d_q == EW'(EMBED_DIM - 1)) begin
          d_d = '0;
          if (i_q == AW'(SEQ_LEN - 1)) begin
            drain_d = 1'b0;
            state_d = S_DRAIN;
          end else begin
            i_d = i_q + AW'(1);
          end
        end else begin
          d_d = d_q + EW'(1);
        end
      end
      // Two cycles let the last product land before the row changes or SAT reads.
      S_DRAIN: if (drain_q) begin
        if (j_q == AW'(SEQ_LEN - 1)) begin
          state_d = S_SAT;
        end else begin
          j_d     = j_q + AW'(1);
          state_d = S_REQ;
        end
      end else begin
        drain_d = 1'b1;
      end
      S_SAT:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (mac_vld) acc_d[mac_tag] = acc_q[mac_tag] + ACC_W'(mac_val);
    if (acc_clr) begin
      for (int k = 0; k < NOUT; k++) acc_d[k] = '0;
    end
  end

  always_comb begin
    out_flat_d = out_flat_q;
    if (state_q == S_SAT) begin
      for (int k = 0; k < NOUT; k++)
        out_flat_d[k*DATA_WIDTH +: DATA_WIDTH] =
          DATA_WIDTH'(sat_to_width(SAT_MAX_W'(acc_q[k]), DATA_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      i_q        <= '0;
      d_q        <= '0;
      k_q        <= '0;
      drain_q    <= 1'b0;
      out_flat_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      i_q        <= i_d;
      d_q        <= d_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      out_flat_q <= out_flat_d;
    end
  end

  // Datapath state needs no reset: V row is refetched and accumulators clear on start.
  always_ff @(posedge clk) begin
    vrow_q <= vrow_d;
    acc_q  <= acc_d;
  end

  assign vif.v_req  = (state_q == S_REQ);
  assign vif.v_addr = j_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_flat   = out_flat_q;
endmodule

// File: tb/tb_sv_mul.sv
// Bench for sv_mul at SEQ_LEN=EMBED_DIM=4: table vectors, random runs vs model, corner sequences.
module tb_sv_mul;
  localparam int DW = 16;
  localparam int SL = 4;
  localparam int ED = 4;
  localparam int FB = 14;
  localparam int AW = 2;
  localparam int NO = SL * ED;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [SL*SL*DW-1:0]  scores_flat;
  logic                 busy, done;
  logic [NO*DW-1:0]     out_flat;

  always #5 clk = ~clk;

  sv_mul_if #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMBED_DIM(ED)) vif ();

  sv_mul #(.DATA_WIDTH(DW), .SEQ_LEN(SL), .EMBED_DIM(ED), .FRAC_BITS(FB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scores_flat (scores_flat),
    .vif         (vif),
    .busy        (busy),
    .done        (done),
    .out_flat    (out_flat)
  );

  logic signed [DW-1:0] sc [SL][SL];
  logic signed [DW-1:0] vm [SL][ED];

  int          errors = 0;
  int          checks = 0;
  int          req_log [$];
  int          addr_err;
  int          wcnt;
  logic        prev_req;
  logic [AW-1:0] prev_addr;

  typedef struct {
    string name;
    int    sc_val;   // -1: identity scores
    int    v_val;    // -1: V[j][d] = j*16+d
    int    wt;
    int    exp_done;
    int    exp_val;  // -1: out[i][d] = i*16+d
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NO*DW-1:0] act, input logic [NO*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pack_scores();
    for (int i = 0; i < SL; i++)
      for (int j = 0; j < SL; j++)
        scores_flat[(i*SL+j)*DW +: DW] = sc[i][j];
  endtask

  task automatic set_ident();
    for (int i = 0; i < SL; i++)
      for (int j = 0; j < SL; j++) sc[i][j] = (i == j) ? 16'sh4000 : 16'sh0000;
    for (int j = 0; j < SL; j++)
      for (int d = 0; d < ED; d++) vm[j][d] = 16'(j*16 + d);
    pack_scores();
  endtask

  // Behavioural reference: floor each product, sum, clamp.
  function automatic logic [NO*DW-1:0] model();
    logic [NO*DW-1:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < ED; d++) begin
        s = 0;
        for (int j = 0; j < SL; j++) s += (longint'(sc[i][j]) * longint'(vm[j][d])) >>> FB;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        r[(i*ED+d)*DW +: DW] = 16'(s);
      end
    return r;
  endfunction

  function automatic logic [NO*DW-1:0] ident_exp();
    logic [NO*DW-1:0] r;
    for (int i = 0; i < SL; i++)
      for (int d = 0; d < ED; d++) r[(i*ED+d)*DW +: DW] = 16'(i*16 + d);
    return r;
  endfunction

  // V-row provider and request monitor, called once per negedge.
  task automatic provide(input int wt);
    if (vif.v_req) begin
      if (!prev_req) req_log.push_back(int'(vif.v_addr));
      else if (vif.v_addr != prev_addr) addr_err++;
      if (wcnt == wt) begin
        vif.v_valid = 1'b1;
        for (int d = 0; d < ED; d++) vif.v_row[d*DW +: DW] = vm[vif.v_addr][d];
      end else begin
        vif.v_valid = 1'b0;
      end
      wcnt++;
    end else begin
      vif.v_valid = 1'b0;
      wcnt = 0;
    end
    prev_req  = vif.v_req;
    prev_addr = vif.v_addr;
  endtask

  // Cycle c below is counted from the cycle in which start is sampled (c=0).
  task automatic run(input int wt, input int rst_at, input int p1, input int p2,
                     input int busy_at, output int done_cyc, output int ndone);
    req_log.delete();
    addr_err = 0;
    wcnt     = 0;
    prev_req = 1'b0;
    done_cyc = -1;
    ndone    = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == busy_at) chk("restart_busy", busy, 1);
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst_busy", busy, 0);
        chk("rst_v_req", vif.v_req, 0);
        chk("rst_done", done, 0);
        chk_vec("rst_out_flat", out_flat, '0);
      end
      provide(wt);
      start = (c == p1) || (c == p2);
      rst   = (c == rst_at);
      if (rst_at >= 0 && c == rst_at + 1) break;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic chk_reqs(input string name);
    chk({name, "_nreq"}, req_log.size(), SL);
    for (int k = 0; k < req_log.size() && k < SL; k++) chk({name, "_addr"}, req_log[k], k);
    chk({name, "_addr_stable"}, addr_err, 0);
  endtask

  initial begin
    vec_t             tbl [5];
    logic [NO*DW-1:0] exp_v;
    logic [15:0]      ev;
    int               dc, nd, wt, c2;

    tbl[0] = '{"ident",      -1,      -1,      0, 78, -1};
    tbl[1] = '{"uniform",    'h1000,  'h4000,  0, 78, 'h4000};
    tbl[2] = '{"sat_pos",    'h7FFF,  'h7FFF,  0, 78, 'h7FFF};
    tbl[3] = '{"sat_neg",    'h7FFF,  'h8000,  0, 78, 'h8000};
    tbl[4] = '{"ident_wait", -1,      -1,      3, 90, -1};

    rst         = 1'b1;
    start       = 1'b0;
    scores_flat = '0;
    vif.v_valid = 1'b0;
    vif.v_row   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_v_req", vif.v_req, 0);
    chk("reset_v_addr", vif.v_addr, 0);
    chk_vec("reset_out_flat", out_flat, '0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < SL; i++)
        for (int j = 0; j < SL; j++)
          sc[i][j] = (tbl[t].sc_val < 0) ? ((i == j) ? 16'sh4000 : 16'sh0000) : 16'(tbl[t].sc_val);
      for (int j = 0; j < SL; j++)
        for (int d = 0; d < ED; d++)
          vm[j][d] = (tbl[t].v_val < 0) ? 16'(j*16 + d) : 16'(tbl[t].v_val);
      pack_scores();
      if (tbl[t].exp_val < 0) exp_v = ident_exp();
      else begin
        ev = 16'(tbl[t].exp_val);
        exp_v = {NO{ev}};
      end
      run(tbl[t].wt, -1, -1, -1, -1, dc, nd);
      chk({tbl[t].name, "_done_cyc"}, dc, tbl[t].exp_done);
      chk({tbl[t].name, "_ndone"}, nd, 1);
      chk_vec({tbl[t].name, "_out"}, out_flat, exp_v);
      chk_reqs(tbl[t].name);
    end

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < SL; i++)
        for (int j = 0; j < SL; j++)
          sc[i][j] = (r < 3) ? 16'($urandom_range(0, 32768) - 16384) : 16'($urandom_range(0, 65535));
      for (int j = 0; j < SL; j++)
        for (int d = 0; d < ED; d++)
          vm[j][d] = (r < 3) ? 16'($urandom_range(0, 32768) - 16384) : 16'($urandom_range(0, 65535));
      pack_scores();
      wt = int'($urandom_range(0, 2));
      run(wt, -1, -1, -1, -1, dc, nd);
      chk("rand_done_cyc", dc, 78 + SL * wt);
      chk_vec("rand_out", out_flat, model());
    end

    // Reset mid-run, then a clean rerun.
    set_ident();
    run(0, 30, -1, -1, -1, dc, nd);
    run(0, -1, -1, -1, -1, dc, nd);
    chk("after_rst_done_cyc", dc, 78);
    chk_vec("after_rst_out", out_flat, ident_exp());

    // Start pulses while busy are ignored.
    run(0, -1, 5, 40, -1, dc, nd);
    chk("pulse_done_cyc", dc, 78);
    chk("pulse_ndone", nd, 1);
    chk_vec("pulse_out", out_flat, ident_exp());

    // Start in the IDLE cycle right after DONE launches a new run.
    run(0, -1, 79, -1, 80, dc, nd);
    chk("hold_first_done", dc, 78);
    c2 = 81;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      c2++;
      if (done) break;
      provide(0);
    end
    chk("hold_second_done", c2, 79 + 78);
    chk_vec("hold_out", out_flat, ident_exp());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
